bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_serial_adder_pkg.sv | 19 +
 rtl/bcd_digit_adder.sv | 25 ++
 rtl/bcd_serial_adder.sv | 132 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared calculator definitions: FSM encodings, size limits and BCD constants
// used by the serial BCD adder and sibling calculator blocks.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } calc_state_e;

    localparam int          CALC_MAX_DIGITS = 8;
    localparam logic [3:0]  BCD_NINE        = 4'd9;
    localparam logic [4:0]  BCD_TEN         = 5'd10;

    function automatic logic bcd_digit_invalid(input logic [3:0] d);
        return d > BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_adder
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] t;

    always_comb begin
        t  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        s  = t[3:0];
        co = 1'b0;
        // Binary sum is at most 19, so one subtraction of ten fully corrects it.
        if (t > {1'b0, BCD_NINE}) begin
            s  = 4'(t - BCD_TEN);
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract: one digit per clock through a shared
// bcd_digit_adder; subtraction uses nines' complement of b plus a forced carry.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][3:0] digits_t;

    calc_state_e   state_q, state_d;
    digits_t       a_q, a_d, b_q, b_d, sum_q, sum_d;
    digits_t       a_in, b_in;
    logic [IDXW-1:0] idx_q, idx_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          invalid_q, invalid_d;
    logic          opnd_bad;

    logic [3:0]    dig_x, dig_y, dig_s;
    logic          dig_co;

    assign a_in = a;
    assign b_in = b;

    always_comb begin
        opnd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_digit_invalid(a_in[i]) || bcd_digit_invalid(b_in[i]))
                opnd_bad = 1'b1;
        end
    end

    assign dig_x = a_q[idx_q];
    assign dig_y = sub_q ? (BCD_NINE - b_q[idx_q]) : b_q[idx_q];

    bcd_digit_adder u_digit (
        .x  (dig_x),
        .y  (dig_y),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    sub_d     = sub;
                    carry_d   = sub ? 1'b1 : cin;
                    sum_d     = '0;
                    cout_d    = 1'b0;
                    idx_d     = '0;
                    invalid_d = opnd_bad;
                    state_d   = opnd_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = dig_s;
                carry_d      = dig_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_co;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder at DIGITS=4: decimal reference model,
// latency/busy/done timing, invalid operands, mid-run reset and ignored starts.
module tb_bcd_serial_adder;

    localparam int D = 4;

    typedef struct packed {
        logic [4*D-1:0] sum;
        logic           cout;
        logic           inv;
    } exp_t;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           start = 1'b0;
    logic           sub   = 1'b0;
    logic           cin   = 1'b0;
    logic [4*D-1:0] a     = '0;
    logic [4*D-1:0] b     = '0;
    logic [4*D-1:0] sum;
    logic           cout, busy, done, invalid;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .sum     (sum),
        .cout    (cout),
        .busy    (busy),
        .done    (done),
        .invalid (invalid)
    );

    always #5 Clock = ~Clock;

    function automatic logic [4*D-1:0] int2bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                                   input logic s, input logic c);
        exp_t e;
        int ai, bi, t, lim;
        logic bad;
        logic [3:0] da, db;
        ai = 0; bi = 0; bad = 1'b0; lim = 1;
        for (int i = D - 1; i >= 0; i--) begin
            da = av[i*4 +: 4];
            db = bv[i*4 +: 4];
            if (da > 4'd9 || db > 4'd9) bad = 1'b1;
            ai = ai * 10 + int'(da);
            bi = bi * 10 + int'(db);
            lim = lim * 10;
        end
        if (bad) begin
            e.sum = '0; e.cout = 1'b0; e.inv = 1'b1;
        end else if (!s) begin
            t = ai + bi + (c ? 1 : 0);
            e.cout = (t >= lim);
            e.sum  = int2bcd(t % lim);
            e.inv  = 1'b0;
        end else begin
            t = ai - bi;
            e.cout = (t >= 0);
            if (t < 0) t = t + lim;
            e.sum = int2bcd(t);
            e.inv = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [4*D-1:0] rand_bcd();
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Returns at the negedge right after the accepting clock edge.
    task automatic issue(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                         input logic s, input logic c);
        @(negedge Clock);
        a = av; b = bv; sub = s; cin = c; start = 1'b1;
        sb.push_back(model(av, bv, s, c));
        @(negedge Clock);
        start = 1'b0;
    endtask

    // lat counts clock edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output int bcnt, output logic [4*D-1:0] mid);
        lat = 0; bcnt = 0; mid = '0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge Clock);
            lat++;
            if (lat == 1) mid = sum;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_vec++;
        if ({sum, cout, busy, done, invalid} !== '0) begin
            n_err++;
            $display("FAIL reset_state got sum=%h c=%b busy=%b done=%b inv=%b want all 0",
                     sum, cout, busy, done, invalid);
        end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_add_sub();
        logic [4*D-1:0] ta[12], tb_[12];
        logic           ts[12], tc[12];
        int lat, bcnt;
        logic [4*D-1:0] mid;
        exp_t e;
        ta[0] = 16'h1234; tb_[0] = 16'h5678; ts[0] = 0; tc[0] = 0;
        ta[1] = 16'h9999; tb_[1] = 16'h0001; ts[1] = 0; tc[1] = 0;
        ta[2] = 16'h0000; tb_[2] = 16'h0000; ts[2] = 0; tc[2] = 1;
        ta[3] = 16'h0500; tb_[3] = 16'h0123; ts[3] = 1; tc[3] = 0;
        ta[4] = 16'h0123; tb_[4] = 16'h0500; ts[4] = 1; tc[4] = 1;
        ta[5] = 16'h9999; tb_[5] = 16'h9999; ts[5] = 0; tc[5] = 1;
        ta[6] = 16'h0000; tb_[6] = 16'h0001; ts[6] = 1; tc[6] = 0;
        ta[7] = 16'h4321; tb_[7] = 16'h4321; ts[7] = 1; tc[7] = 0;
        for (int i = 8; i < 12; i++) begin
            ta[i] = rand_bcd(); tb_[i] = rand_bcd();
            ts[i] = 1'($urandom_range(0, 1)); tc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 12; i++) begin
            issue(ta[i], tb_[i], ts[i], tc[i]);
            // Operands change after acceptance and must not matter.
            a = rand_bcd(); b = rand_bcd(); sub = ~sub; cin = ~cin;
            wait_done(lat, bcnt, mid);
            n_vec++;
            if (done !== 1'b1 || sb.size() == 0) begin
                n_err++;
                $display("FAIL op%0d_done got done=%b q=%0d want done=1", i, done, sb.size());
                continue;
            end
            e = sb.pop_front();
            n_vec++;
            if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                n_err++;
                $display("FAIL op%0d_result got sum=%h c=%b inv=%b want sum=%h c=%b inv=%b",
                         i, sum, cout, invalid, e.sum, e.cout, e.inv);
            end
            n_vec++;
            if (lat != D || bcnt != D) begin
                n_err++;
                $display("FAIL op%0d_latency got lat=%0d busy=%0d want %0d/%0d", i, lat, bcnt, D, D);
            end
            n_vec++;
            if (mid !== {12'h000, e.sum[3:0]}) begin
                n_err++;
                $display("FAIL op%0d_partial got %h want %h", i, mid, {12'h000, e.sum[3:0]});
            end
            @(negedge Clock);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== e.sum || cout !== e.cout) begin
                n_err++;
                $display("FAIL op%0d_hold got done=%b busy=%b sum=%h c=%b want 0 0 %h %b",
                         i, done, busy, sum, cout, e.sum, e.cout);
            end
        end
    endtask

    task automatic test_invalid();
        logic [4*D-1:0] ia[2], ib[2];
        int lat, bcnt;
        logic [4*D-1:0] mid;
        exp_t e;
        ia[0] = 16'h12A4; ib[0] = 16'h0001;
        ia[1] = 16'h0001; ib[1] = 16'hF000;
        for (int i = 0; i < 2; i++) begin
            issue(ia[i], ib[i], 1'(i), 1'b0);
            wait_done(lat, bcnt, mid);
            e = sb.pop_front();
            n_vec++;
            if (done !== 1'b1 || lat != 0 || bcnt != 0) begin
                n_err++;
                $display("FAIL inv%0d_timing got done=%b lat=%0d busy=%0d want 1 0 0", i, done, lat, bcnt);
            end
            n_vec++;
            if ({sum, cout, invalid} !== {e.sum, e.cout, e.inv}) begin
                n_err++;
                $display("FAIL inv%0d_result got sum=%h c=%b inv=%b want %h %b %b",
                         i, sum, cout, invalid, e.sum, e.cout, e.inv);
            end
            @(negedge Clock);
            n_vec++;
            if (done !== 1'b0 || invalid !== 1'b1) begin
                n_err++;
                $display("FAIL inv%0d_hold got done=%b inv=%b want 0 1", i, done, invalid);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat, bcnt;
        logic [4*D-1:0] mid;
        exp_t e;
        issue(16'h1234, 16'h5678, 1'b0, 1'b0);
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        sb.delete();
        n_vec++;
        if ({sum, cout, busy, done, invalid} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset got sum=%h c=%b busy=%b done=%b inv=%b want all 0",
                     sum, cout, busy, done, invalid);
        end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
        issue(16'h0042, 16'h0058, 1'b0, 1'b0);
        wait_done(lat, bcnt, mid);
        e = sb.pop_front();
        n_vec++;
        if (done !== 1'b1 || sum !== e.sum || cout !== e.cout || lat != D) begin
            n_err++;
            $display("FAIL first_after_reset got done=%b sum=%h c=%b lat=%0d want 1 %h %b %0d",
                     done, sum, cout, lat, e.sum, e.cout, D);
        end
        @(negedge Clock);
    endtask

    task automatic test_start_while_busy();
        int pulses;
        exp_t e;
        pulses = 0;
        issue(16'h0777, 16'h0333, 1'b0, 1'b1);
        a = 16'h9999; b = 16'h9999; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (sum !== e.sum || cout !== e.cout) begin
                        n_err++;
                        $display("FAIL busy_start_result got sum=%h c=%b want %h %b",
                                 sum, cout, e.sum, e.cout);
                    end
                end
            end
            @(negedge Clock);
        end
        n_vec++;
        if (pulses != 1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL busy_start_pulses got %0d (q=%0d) want 1", pulses, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [4*D-1:0] mid;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(rand_bcd(), rand_bcd(), 1'(i & 1), 1'b1);
            wait_done(lat, bcnt, mid);
            e = sb.pop_front();
            n_vec++;
            if (done !== 1'b1 || sum !== e.sum || cout !== e.cout || invalid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b%0d got done=%b sum=%h c=%b inv=%b want 1 %h %b 0",
                         i, done, sum, cout, invalid, e.sum, e.cout);
            end
        end
        @(negedge Clock);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_invalid();
        test_reset_midrun();
        test_start_while_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
